// File: rtl/cdb_pkg.sv
// ---------------------------------------------------------------------------
// cdb_pkg : shared types, defaults and pointer helper for the CDB arbiter
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none
package cdb_pkg;

  localparam int CDB_W_DEF  = 4;
  localparam int CDB_TAG_W  = 6;
  localparam int CDB_DATA_W = 32;

  typedef struct packed {
    logic                  valid;
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] val;
  } cdb_entry_t;

  // Slot after the last granted producer, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned last, input int unsigned n);
    return (last + 1 >= n) ? 0 : last + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/global_config_pkg.sv
// Minimal global configuration package supplying the core word length to cdb_arbiter.
`default_nettype none
package global_config_pkg;

  typedef struct packed {
    int unsigned ILEN;
  } cfg_t;

  localparam cfg_t Cfg = '{ILEN: 32};

endpackage
`default_nettype wire

// File: rtl/cdb_arbiter_rr_multi_pick.sv
// ---------------------------------------------------------------------------
// rr_multi_pick : combinational multi-grant round-robin picker
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none
module rr_multi_pick #(
  parameter int N     = 6,
  parameter int W     = 4,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [W-1:0]     lane_valid,
  output logic [IDX_W-1:0] lane_idx [W],
  output logic [IDX_W-1:0] last_idx
);

  int pos;
  int cnt;

  // Walk producers from ptr with wrap; the k-th hit fills lane k.
  always_comb begin
    gnt        = '0;
    lane_valid = '0;
    last_idx   = '0;
    pos        = 0;
    cnt        = 0;
    for (int k = 0; k < W; k++) lane_idx[k] = '0;
    for (int off = 0; off < N; off++) begin
      pos = int'(ptr) + off;
      if (pos >= N) pos = pos - N;
      for (int i = 0; i < N; i++) begin
        if (i == pos && req[i] && cnt < W) begin
          gnt[i] = 1'b1;
          for (int k = 0; k < W; k++) begin
            if (k == cnt) begin
              lane_valid[k] = 1'b1;
              lane_idx[k]   = IDX_W'(i);
            end
          end
          last_idx = IDX_W'(i);
          cnt      = cnt + 1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter : round-robin write-back scheduler onto registered CDB lanes.
// Optional stat counters built when CDB_ARB_STATS_EN is defined.
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter global_config_pkg::cfg_t Cfg = global_config_pkg::Cfg,
  parameter int N_SRC  = 6,
  parameter int CDB_W  = CDB_W_DEF,
  parameter int DATA_W = int'(Cfg.ILEN),
  parameter int TAG_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic [N_SRC-1:0]  src_valid_i,
  input  logic [TAG_W-1:0]  src_tag_i [N_SRC],
  input  logic [DATA_W-1:0] src_val_i [N_SRC],
  output logic [N_SRC-1:0]  src_ready_o,
  output logic [CDB_W-1:0]  cdb_valid_o,
  output logic [TAG_W-1:0]  cdb_tag_o [CDB_W],
  output logic [DATA_W-1:0] cdb_val_o [CDB_W],
  output logic [31:0]       stat_xfer_cnt_o,
  output logic [31:0]       stat_conflict_cnt_o
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [IDX_W-1:0]  rr_ptr;
  logic [N_SRC-1:0]  req;
  logic [N_SRC-1:0]  gnt;
  logic [CDB_W-1:0]  lane_valid;
  logic [IDX_W-1:0]  lane_idx [CDB_W];
  logic [IDX_W-1:0]  last_idx;
  logic [IDX_W-1:0]  next_ptr;
  logic [TAG_W-1:0]  next_tag [CDB_W];
  logic [DATA_W-1:0] next_val [CDB_W];

  // Flush masks requests, so nothing is granted and the pointer holds.
  assign req = flush_i ? '0 : src_valid_i;

  rr_multi_pick #(
    .N     (N_SRC),
    .W     (CDB_W),
    .IDX_W (IDX_W)
  ) u_pick (
    .req        (req),
    .ptr        (rr_ptr),
    .gnt        (gnt),
    .lane_valid (lane_valid),
    .lane_idx   (lane_idx),
    .last_idx   (last_idx)
  );

  assign src_ready_o = rst ? '0 : gnt;
  assign next_ptr    = IDX_W'(rr_next(32'(last_idx), N_SRC));

  always_comb begin
    for (int k = 0; k < CDB_W; k++) begin
      next_tag[k] = '0;
      next_val[k] = '0;
      for (int i = 0; i < N_SRC; i++) begin
        if (lane_valid[k] && lane_idx[k] == IDX_W'(i)) begin
          next_tag[k] = src_tag_i[i];
          next_val[k] = src_val_i[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr      <= '0;
      cdb_valid_o <= '0;
      for (int k = 0; k < CDB_W; k++) begin
        cdb_tag_o[k] <= '0;
        cdb_val_o[k] <= '0;
      end
    end else begin
      cdb_valid_o <= lane_valid;
      for (int k = 0; k < CDB_W; k++) begin
        cdb_tag_o[k] <= next_tag[k];
        cdb_val_o[k] <= next_val[k];
      end
      if (|gnt) rr_ptr <= next_ptr;
    end
  end

`ifdef CDB_ARB_STATS_EN
  logic [31:0] xfer_cnt;
  logic [31:0] conflict_cnt;
  logic [31:0] n_gnt;
  logic [31:0] n_req;

  // Raw valids are counted so flushed producers register as conflicts.
  assign n_gnt = 32'($countones(gnt));
  assign n_req = 32'($countones(src_valid_i));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt     <= '0;
      conflict_cnt <= '0;
    end else begin
      xfer_cnt <= xfer_cnt + n_gnt;
      if (n_req > n_gnt) conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

  assign stat_xfer_cnt_o     = xfer_cnt;
  assign stat_conflict_cnt_o = conflict_cnt;
`else
  assign stat_xfer_cnt_o     = 32'd0;
  assign stat_conflict_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// Directed + randomized scoreboard bench for cdb_arbiter (N_SRC=6, CDB_W=4).
`default_nettype none
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic [5:0]  src_valid_i;
  logic [5:0]  src_tag_i [6];
  logic [31:0] src_val_i [6];
  logic [5:0]  src_ready_o;
  logic [3:0]  cdb_valid_o;
  logic [5:0]  cdb_tag_o [4];
  logic [31:0] cdb_val_o [4];
  logic [31:0] stat_xfer_cnt_o;
  logic [31:0] stat_conflict_cnt_o;

  typedef struct packed {
    logic [3:0]       v;
    logic [3:0][5:0]  tag;
    logic [3:0][31:0] val;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          mptr = 0;
  logic [31:0] m_xfer = 0;
  logic [31:0] m_conf = 0;
  logic [5:0]  obs_ready;
  logic        seen;

  cdb_arbiter #(
    .N_SRC  (6),
    .CDB_W  (4),
    .DATA_W (32),
    .TAG_W  (6)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush_i             (flush_i),
    .src_valid_i         (src_valid_i),
    .src_tag_i           (src_tag_i),
    .src_val_i           (src_val_i),
    .src_ready_o         (src_ready_o),
    .cdb_valid_o         (cdb_valid_o),
    .cdb_tag_o           (cdb_tag_o),
    .cdb_val_o           (cdb_val_o),
    .stat_xfer_cnt_o     (stat_xfer_cnt_o),
    .stat_conflict_cnt_o (stat_conflict_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: scan from ptr with wrap, first four valid producers win.
  function automatic void model(input logic [5:0] v, input logic fl, input int ptr,
                                output logic [5:0] rdy, output exp_t e, output int nptr);
    int cnt = 0;
    int i;
    rdy  = '0;
    e    = '0;
    nptr = ptr;
    if (!fl) begin
      for (int off = 0; off < 6; off++) begin
        i = (ptr + off) % 6;
        if (v[i] && cnt < 4) begin
          rdy[i]     = 1'b1;
          e.v[cnt]   = 1'b1;
          e.tag[cnt] = src_tag_i[i];
          e.val[cnt] = src_val_i[i];
          nptr       = (i + 1) % 6;
          cnt++;
        end
      end
    end
  endfunction

  task automatic check_stats();
`ifdef CDB_ARB_STATS_EN
    check("stat_xfer", stat_xfer_cnt_o, m_xfer);
    check("stat_conflict", stat_conflict_cnt_o, m_conf);
`else
    check("stat_xfer_off", stat_xfer_cnt_o, 0);
    check("stat_conflict_off", stat_conflict_cnt_o, 0);
`endif
  endtask

  task automatic step(input logic fl, input logic [5:0] v);
    logic [5:0] rdy;
    exp_t       e;
    exp_t       got;
    int         np;
    @(negedge clk);
    flush_i     = fl;
    src_valid_i = v;
    #1;
    model(v, fl, mptr, rdy, e, np);
    obs_ready = src_ready_o;
    check("src_ready", src_ready_o, rdy);
    q.push_back(e);
    m_xfer = m_xfer + 32'($countones(rdy));
    if ($countones(v) > $countones(rdy)) m_conf = m_conf + 1;
    @(posedge clk);
    #1;
    got = q.pop_front();
    check("cdb_valid", cdb_valid_o, got.v);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("lane%0d_tag", k), cdb_tag_o[k], got.tag[k]);
      check($sformatf("lane%0d_val", k), cdb_val_o[k], got.val[k]);
    end
    mptr = np;
    check("rr_ptr", dut.rr_ptr, mptr);
    check_stats();
    for (int i = 0; i < 6; i++) begin
      if (rdy[i]) begin
        src_tag_i[i] = 6'($urandom);
        src_val_i[i] = $urandom;
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    flush_i     = 1'b0;
    src_valid_i = 6'h3f;
    for (int i = 0; i < 6; i++) begin
      src_tag_i[i] = 6'(i + 10);
      src_val_i[i] = 32'h1000 + 32'(i);
    end
    @(negedge clk);
    @(negedge clk);
    check("reset_ready", src_ready_o, 0);
    check("reset_cdb_valid", cdb_valid_o, 0);
    check("reset_tag0", cdb_tag_o[0], 0);
    check("reset_val3", cdb_val_o[3], 0);
    check("reset_ptr", dut.rr_ptr, 0);
    check_stats();
    src_valid_i = 6'h00;
    rst         = 1'b0;

    // Single producer
    src_tag_i[0] = 6'd5;
    src_val_i[0] = 32'h0000DEAD;
    step(1'b0, 6'b000001);
    check("t1_ready", obs_ready, 6'b000001);
    check("t1_valid", cdb_valid_o, 4'b0001);
    check("t1_tag", cdb_tag_o[0], 6'd5);
    check("t1_val", cdb_val_o[0], 32'h0000DEAD);
    check("t1_ptr", dut.rr_ptr, 1);

    // Asynchronous reset with results in flight
    @(negedge clk);
    src_valid_i = 6'h3f;
    rst         = 1'b1;
    #1;
    check("midrst_ready", src_ready_o, 0);
    check("midrst_valid", cdb_valid_o, 0);
    check("midrst_ptr", dut.rr_ptr, 0);
    @(negedge clk);
    rst         = 1'b0;
    src_valid_i = 6'h00;
    mptr   = 0;
    m_xfer = 0;
    m_conf = 0;

    // All producers valid for two cycles
    step(1'b0, 6'h3f);
    check("t2a_ready", obs_ready, 6'b001111);
    check("t2a_ptr", dut.rr_ptr, 4);
    step(1'b0, 6'h3f);
    check("t2b_ready", obs_ready, 6'b110011);
    check("t2b_ptr", dut.rr_ptr, 2);
`ifdef CDB_ARB_STATS_EN
    check("t6_xfer", stat_xfer_cnt_o, 8);
    check("t6_conflict", stat_conflict_cnt_o, 2);
`else
    check("t6_xfer_off", stat_xfer_cnt_o, 0);
    check("t6_conflict_off", stat_conflict_cnt_o, 0);
`endif

    // Wrap-around from pointer 5
    step(1'b0, 6'b001000);
    step(1'b0, 6'b010000);
    check("t3_ptr5", dut.rr_ptr, 5);
    step(1'b0, 6'b100010);
    check("t3_ready", obs_ready, 6'b100010);
    check("t3_valid", cdb_valid_o, 4'b0011);
    check("t3_ptr", dut.rr_ptr, 2);

    // Flush beats valid; pointer preserved
    step(1'b1, 6'b000111);
    check("t4_ready", obs_ready, 6'b000000);
    check("t4_valid", cdb_valid_o, 4'b0000);
    check("t4_ptr", dut.rr_ptr, 2);
    step(1'b0, 6'b000111);
    check("t4_after_ready", obs_ready, 6'b000111);
    check("t4_after_valid", cdb_valid_o, 4'b0111);

    // Starvation: src0 granted within two saturated cycles
    step(1'b0, 6'b000001);
    seen = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 6'h3f);
      seen = seen | obs_ready[0];
    end
    check("t5_src0_granted", seen, 1'b1);

    // Randomized traffic with occasional flush
    for (int n = 0; n < 40; n++) begin
      step($urandom_range(0, 7) == 0, 6'($urandom));
    end
    step(1'b0, 6'h00);

    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus arbiter and write-back scheduler for the out-of-order backend. It collects completed results from up to `N_SRC` functional units (ALUs, LSU, MUL/DIV) and grants at most `CDB_W` of them per cycle onto the CDB lanes. Grants rotate round-robin so no unit starves. The registered CDB outputs feed the issue queue's wake-up/forwarding ports (`cdb_valid`/`cdb_tag`/`cdb_val`) and the ROB.

## Interface
Parameters:
- `Cfg`, `global_config_pkg::Cfg`: global configuration.
- `N_SRC`, 6: number of result producers.
- `CDB_W`, 4: number of CDB lanes. Requires `CDB_W <= N_SRC`.
- `DATA_W`, `Cfg.ILEN`: result width.
- `TAG_W`, 6: physical tag width.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: asynchronous, active-high reset.
- `flush_i`  in  1: pipeline flush.
- `src_valid_i`  in  `N_SRC`: producer i holds a result.
- `src_tag_i[N_SRC]`  in  `TAG_W`: destination tag.
- `src_val_i[N_SRC]`  in  `DATA_W`: result value.
- `src_ready_o`  out  `N_SRC`: producer i is granted this cycle.
- `cdb_valid_o`  out  `CDB_W`: lane valid.
- `cdb_tag_o[CDB_W]`  out  `TAG_W`: lane tag.
- `cdb_val_o[CDB_W]`  out  `DATA_W`: lane value.
- `stat_xfer_cnt_o`  out  32: total granted results.
- `stat_conflict_cnt_o`  out  32: cycles in which at least one valid producer was not granted.

## Operation
- A transfer happens on `src_valid_i[i] && src_ready_o[i]`.
- Once a producer raises valid, it holds valid, tag and value stable until it sees ready.
- `src_ready_o` is combinational from `src_valid_i`, the rotation pointer `rr_ptr`, and `flush_i`. `src_ready_o[i]` is never 1 while `src_valid_i[i]` is 0.
- Selection: scan producers starting at index `rr_ptr` and wrapping modulo `N_SRC`. Grant the first `CDB_W` valid producers found.
- Lane packing: the k-th grant in scan order goes to lane k. Lanes are packed from 0 upward with no holes.
- Pointer update: after a cycle with at least one grant, `rr_ptr` = (index of the last granted producer + 1) mod `N_SRC`. With no grants, `rr_ptr` is unchanged.
- Lanes that carry no grant have valid = 0 and tag/value = 0.
- Flush while `flush_i` = 1:
  - `src_ready_o` = 0, so no transfers.
  - All CDB outputs are cleared on the next edge.
  - `rr_ptr` is preserved.
- Fewer than `CDB_W` valid producers: all of them are granted in the same cycle.

## Timing
- Latency: a result handshaked in cycle t appears on the CDB in cycle t+1. There is no internal buffering beyond the output register.
- Throughput: up to `CDB_W` results per cycle.
- Reset values: `cdb_valid_o` = 0, `cdb_tag_o` = 0, `cdb_val_o` = 0, `rr_ptr` = 0, both stat counters = 0. `src_ready_o` = 0 while `rst` is asserted.
- A reset asserted mid-operation discards any result that is in flight.
- Flush and valid in the same cycle: flush wins.
- Stat counters wrap at 2^32.

## Configuration
- Macro `CDB_ARB_STATS_EN`.
- Defined: both stat counters are implemented.
  - `stat_xfer_cnt_o` += popcount(grants) each cycle.
  - `stat_conflict_cnt_o` += 1 when popcount(valid) > popcount(grants).
  - During flush, all valid producers count as not granted.
- Undefined: no counter flops are built. Both stat ports are tied to 0. Ports are present in both builds.

## Structure
- Shared package `cdb_pkg` holds:
  - `cdb_entry_t` (`valid`, `tag`, `val`);
  - `CDB_W` default constant;
  - `rr_next()` function used for the pointer update.
- Sub-module `rr_multi_pick`: combinational multi-grant round-robin picker.
  - Inputs: request vector, start pointer.
  - Outputs: grant vector, per-lane source index, last-grant index.
- The parent `cdb_arbiter` owns the output register, `rr_ptr`, flush gating and the stat counters.

## Test plan
All scenarios use `N_SRC` = 6, `CDB_W` = 4.
1. Reset, then `src_valid` = 6'b000001 with tag 5 and value 0x0000DEAD → `src_ready` = 6'b000001. Next cycle: `cdb_valid` = 4'b0001, lane 0 tag = 5, value = 0xDEAD, `rr_ptr` = 1.
2. All 6 producers valid, `rr_ptr` = 0 → `src_ready` = 6'b001111, lanes 0..3 = src0..3, `rr_ptr` = 4. Producers keep new data valid. Next cycle grants src4, src5, src0, src1 on lanes 0..3; `rr_ptr` = 2.
3. Wrap-around: `rr_ptr` = 5, valid = 6'b100010 → lane 0 = src5, lane 1 = src1, `cdb_valid` = 4'b0011, `rr_ptr` = 2.
4. Flush: 3 producers valid with `flush_i` = 1 → `src_ready` = 0. Next cycle `cdb_valid` = 0 and `rr_ptr` is unchanged. Producers still valid after flush drops are granted normally.
5. Starvation check: src0 held valid continuously while src1..src5 are all valid every cycle → src0 is granted within 2 cycles.
6. With `CDB_ARB_STATS_EN`: scenario 2 for 2 cycles → `stat_xfer_cnt_o` = 8, `stat_conflict_cnt_o` = 2. Without the macro, both ports stay 0.
